mul_share_sched: RTL and testbench
==================================

# mul_share_sched

Scheduler that shares the single shift-add multiplier datapath between `N_REQ` requesters. It arbitrates round-robin and loads the winner's operands. It then sequences the datapath through its fixed `STEPS` control pattern (`sela`, `selb`, `sel_shifter`) and returns the product to the granted requester. It sits between the requester-side blocks and the multiplier datapath, and replaces per-requester start/done wiring.

## Interface
Parameters:
- `N_REQ`, 2, number of requesters (2..4)
- `W`, 8, operand width; product width is 2W
- `STEPS`, 4, datapath control steps per multiply (fixed pattern below; only 4 supported)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-low reset (sampled on `clk` rising edge)
- `req_valid`  in  N_REQ  per-requester request, level, held until `req_ack`
- `req_a`  in  N_REQ*W  operand A, slice i belongs to requester i
- `req_b`  in  N_REQ*W  operand B, slice i belongs to requester i
- `req_ack`  out  N_REQ  one-hot, one-cycle pulse: request accepted
- `rsp_valid`  out  N_REQ  one-hot, one-cycle pulse: product available
- `rsp_data`  out  2W  product, valid only while any `rsp_valid` bit is high
- `busy`  out  1  high in every state except IDLE
- `dp_load`  out  1  datapath loads `dp_opa`/`dp_opb`
- `dp_opa`, `dp_opb`  out  W  operands of granted requester
- `dp_sela`, `dp_selb`  out  1  datapath operand selects
- `dp_sel_shifter`  out  2  datapath shifter select
- `dp_result`  in  2W  datapath product, valid in the cycle after the last step

## Operation
States: IDLE, LOAD, STEP, DONE.
- **IDLE:** if any `req_valid` is set, the arbiter picks winner `g`, `g` is registered, and the state goes to LOAD. Otherwise the block stays in IDLE.
- **LOAD (1 cycle):** `dp_load`=1 and `req_ack[g]`=1. `dp_opa`/`dp_opb` carry the slices of requester `g`. The step counter k is cleared to 0. The state goes to STEP.
- **STEP (STEPS cycles, k=0..3):** drives `{dp_sela, dp_selb, dp_sel_shifter}` as follows:
  - k=0: 1,1,10
  - k=1: 1,0,01
  - k=2: 0,1,01
  - k=3: 0,0,00
  - k increments each cycle. After k=3 the state goes to DONE.
- **DONE (1 cycle):** `rsp_valid[g]`=1 and `rsp_data`=`dp_result`. The arbiter evaluates `req_valid` in the same cycle. If any request is pending, the state goes straight to LOAD with the new winner; otherwise it goes to IDLE.
- **Datapath outputs outside their states:** `dp_sel*`=0 outside STEP, `dp_load`=0 outside LOAD, and `dp_opa`/`dp_opb`=0 outside LOAD. No X is ever driven.
- **Arbitration:** round-robin. The pointer `last` holds the most recent grant. The search starts at `last+1` and wraps modulo `N_REQ`. `last` updates only on a grant.
- **Request/response rules:**
  - A requester may drop `req_valid` before being acked; that is legal, and the request is simply not served.
  - A requester must deassert in the cycle after `req_ack`. If `req_valid` is still high in DONE, it is treated as a new request.
  - There is no backpressure on `rsp_valid`; the requester must consume the response in the pulse cycle.
- **Operand capture:** operands are sampled only in LOAD. Changes afterwards have no effect.

## Timing
- **Reset:** state=IDLE and `last`=N_REQ-1, so requester 0 wins first. Every output is 0 at reset.
- **Reset mid-operation:** same as reset. `rsp_valid` is not issued for the aborted job.
- **Latency:** `req_valid` high in IDLE at cycle t gives LOAD and `req_ack` at t+1, STEP at t+2..t+5, and DONE with `rsp_valid` at t+6.
- **Throughput:** back-to-back jobs take 6 cycles each (LOAD+4 STEP+DONE); IDLE is skipped.
- **Simultaneous requests:** exactly one is granted; the others wait without loss while held.
- **`busy`:** rises at t+1 and falls after DONE only if no new request is pending.

## Structure
- Package `mul_sched_pkg`:
  - state enum (IDLE, LOAD, STEP, DONE)
  - step-control constants `STEP_SELA[4]`, `STEP_SELB[4]`, `STEP_SHIFT[4]`
  - constant `MUL_STEPS`=4
- Sub-module `rr_arbiter` (`N_REQ` parameter; inputs `req` and `en`; output one-hot `grant`; holds the `last` pointer internally and updates it when `en` and a grant is made).
- Top level: FSM, step counter, granted-index register, operand mux.

## Test plan
The bench uses a behavioral 4-step datapath model that returns a*b.
- **Single request:** `req_valid`=01 with a=13, b=11 -> `req_ack`=01 at t+1, control sequence 11/10, 10/01, 01/01, 00/00 at t+2..t+5, `rsp_valid`=01 with `rsp_data`=143 at t+6.
- **Simultaneous requests after reset:** `req_valid`=11 (req0 a=5, b=7; req1 a=255, b=255) -> req0 served first with 35 at t+6. req1 is acked in DONE->LOAD, and `rsp_data`=65025 arrives at t+12. `busy` stays high throughout.
- **Fairness:** both requests held continuously for 4 jobs -> grants alternate 0,1,0,1.
- **Reset mid-operation:** `rst`=0 during STEP k=2 -> next cycle all outputs are 0 and state is IDLE, no `rsp_valid`. A subsequent request is granted to requester 0.
- **Edge and illegal-timing cases:**
  - Operand change after ack: product still reflects the LOAD-cycle operands.
  - Request dropped before ack: no ack and no response.
  - a=0, b=200: `rsp_data`=0.

Source files
------------

// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the multiplier-sharing scheduler.
package mul_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int MUL_STEPS = 4;

  // Datapath control pattern, indexed by step counter k (bit k = step k).
  localparam logic [MUL_STEPS-1:0]      STEP_SELA  = 4'b0011;
  localparam logic [MUL_STEPS-1:0]      STEP_SELB  = 4'b0101;
  localparam logic [MUL_STEPS-1:0][1:0] STEP_SHIFT = {2'b00, 2'b01, 2'b01, 2'b10};

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last grant and wraps.
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0] last_q, last_d;
  logic          found;
  int            idx;

  // First requester at or after last+1 (mod N_REQ) wins; pointer moves only on a grant.
  always_comb begin
    grant  = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = 0;
    if (en) begin
      for (int off = 1; off <= N_REQ; off++) begin
        idx = (int'(last_q) + off) % N_REQ;
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          last_d     = IW'(idx);
        end
      end
    end
  end

  // Reset points at the top requester so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst) last_q <= IW'(N_REQ - 1);
    else      last_q <= last_d;
  end

endmodule

// File: rtl/mul_share_sched.sv
// Shares one shift-add multiplier datapath between N_REQ requesters:
// arbitrate, load operands, sequence the 4 control steps, return the product.
module mul_share_sched
  import mul_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int W     = 8,
  parameter int STEPS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [2*W-1:0]     rsp_data,
  output logic               busy,
  output logic               dp_load,
  output logic [W-1:0]       dp_opa,
  output logic [W-1:0]       dp_opb,
  output logic               dp_sela,
  output logic               dp_selb,
  output logic [1:0]         dp_sel_shifter,
  input  logic [2*W-1:0]     dp_result
);

  localparam int GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Only the 4-step pattern exists; any other STEPS value falls back to it.
  localparam int LAST_K = (STEPS == MUL_STEPS) ? STEPS - 1 : MUL_STEPS - 1;

  state_e          state_q, state_d;
  logic [1:0]      k_q, k_d;
  logic [GW-1:0]   g_q, g_d;

  logic            arb_en;
  logic [N_REQ-1:0] grant;
  logic [GW-1:0]   gidx;
  logic [N_REQ-1:0] g_oh;

  // The arbiter only looks at requests when a new job can start.
  assign arb_en = (state_q == S_IDLE) || (state_q == S_DONE);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .en    (arb_en),
    .grant (grant)
  );

  // One-hot grant to index.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) gidx = GW'(i);
  end

  // Next-state logic; DONE chains straight into LOAD when a request is pending.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    g_d     = g_q;
    unique case (state_q)
      S_IDLE: if (|grant) begin
        state_d = S_LOAD;
        g_d     = gidx;
      end
      S_LOAD: begin
        state_d = S_STEP;
        k_d     = 2'd0;
      end
      S_STEP: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'(LAST_K)) state_d = S_DONE;
      end
      S_DONE: begin
        if (|grant) begin
          state_d = S_LOAD;
          g_d     = gidx;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, step counter and granted index; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      g_q     <= g_d;
    end
  end

  // Outputs decode the state flops; everything is forced to 0 outside its state.
  assign g_oh           = N_REQ'(1) << g_q;
  assign busy           = (state_q != S_IDLE);
  assign dp_load        = (state_q == S_LOAD);
  assign req_ack        = dp_load ? g_oh : '0;
  assign dp_opa         = dp_load ? req_a[g_q*W +: W] : '0;
  assign dp_opb         = dp_load ? req_b[g_q*W +: W] : '0;
  assign dp_sela        = (state_q == S_STEP) ? STEP_SELA[k_q]  : 1'b0;
  assign dp_selb        = (state_q == S_STEP) ? STEP_SELB[k_q]  : 1'b0;
  assign dp_sel_shifter = (state_q == S_STEP) ? STEP_SHIFT[k_q] : 2'b00;
  assign rsp_valid      = (state_q == S_DONE) ? g_oh : '0;
  assign rsp_data       = (state_q == S_DONE) ? dp_result : '0;

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched with a behavioral 4-step datapath model.
module tb_mul_share_sched;

  localparam int N_REQ = 2;
  localparam int W     = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N_REQ-1:0]   req_valid = '0;
  logic [N_REQ*W-1:0] req_a = '0;
  logic [N_REQ*W-1:0] req_b = '0;
  logic [N_REQ-1:0]   req_ack;
  logic [N_REQ-1:0]   rsp_valid;
  logic [2*W-1:0]     rsp_data;
  logic               busy;
  logic               dp_load;
  logic [W-1:0]       dp_opa;
  logic [W-1:0]       dp_opb;
  logic               dp_sela;
  logic               dp_selb;
  logic [1:0]         dp_sel_shifter;
  logic [2*W-1:0]     dp_result;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {sela, selb, shifter} for k = 0..3.
  logic [3:0] exp_ctl [4] = '{4'b1110, 4'b1001, 4'b0101, 4'b0000};

  mul_share_sched #(.N_REQ(N_REQ), .W(W), .STEPS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_a          (req_a),
    .req_b          (req_b),
    .req_ack        (req_ack),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .busy           (busy),
    .dp_load        (dp_load),
    .dp_opa         (dp_opa),
    .dp_opb         (dp_opb),
    .dp_sela        (dp_sela),
    .dp_selb        (dp_selb),
    .dp_sel_shifter (dp_sel_shifter),
    .dp_result      (dp_result)
  );

  always #5 clk = ~clk;

  // Datapath model: captures operands on load, product valid 4 cycles later.
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [2:0]   m_cnt = 3'd5;
  always @(posedge clk) begin
    if (dp_load) begin
      m_a   <= dp_opa;
      m_b   <= dp_opb;
      m_cnt <= 3'd0;
    end else if (m_cnt < 3'd4) begin
      m_cnt <= m_cnt + 3'd1;
    end
  end
  assign dp_result = (m_cnt == 3'd4) ? (2*W)'(m_a * m_b) : '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 2'b11;
    set_ops(0, 8'd3, 8'd4);
    tick();
    tick();
    n_tests++;
    if ({req_ack, rsp_valid, rsp_data, busy, dp_load, dp_opa, dp_opb, dp_sela, dp_selb, dp_sel_shifter} !== '0)
      begin n_fail++; $display("FAIL reset_outputs ack=%b rspv=%b data=%0d busy=%b load=%b opa=%0d sel=%b%b%b want all 0",
        req_ack, rsp_valid, rsp_data, busy, dp_load, dp_opa, dp_sela, dp_selb, dp_sel_shifter); end
    req_valid = '0;
    rst = 1'b1;
    tick();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy=%b want 0", busy); end
  endtask

  task automatic test_single();
    set_ops(0, 8'd13, 8'd11);
    req_valid = 2'b01;
    tick();
    n_tests++;
    if ({req_ack, dp_load, busy, dp_opa, dp_opb} !== {2'b01, 1'b1, 1'b1, 8'd13, 8'd11})
      begin n_fail++; $display("FAIL single_load ack=%b load=%b busy=%b opa=%0d opb=%0d want 01 1 1 13 11",
        req_ack, dp_load, busy, dp_opa, dp_opb); end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if ({dp_sela, dp_selb, dp_sel_shifter, dp_load, busy, dp_opa, dp_opb, req_ack, rsp_valid}
          !== {exp_ctl[k], 1'b0, 1'b1, 8'd0, 8'd0, 2'b00, 2'b00})
        begin n_fail++; $display("FAIL single_step%0d ctl=%b%b%b load=%b busy=%b opa=%0d ack=%b rspv=%b want ctl=%b",
          k, dp_sela, dp_selb, dp_sel_shifter, dp_load, busy, dp_opa, req_ack, rsp_valid, exp_ctl[k]); end
    end
    tick();
    n_tests++;
    if ({rsp_valid, rsp_data, req_ack, busy} !== {2'b01, 16'd143, 2'b00, 1'b1})
      begin n_fail++; $display("FAIL single_done rspv=%b data=%0d ack=%b busy=%b want 01 143 00 1",
        rsp_valid, rsp_data, req_ack, busy); end
    tick();
    n_tests++;
    if ({busy, rsp_valid, rsp_data} !== '0)
      begin n_fail++; $display("FAIL single_idle busy=%b rspv=%b data=%0d want 0", busy, rsp_valid, rsp_data); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_ops(0, 8'd5, 8'd7);
    set_ops(1, 8'd255, 8'd255);
    req_valid = 2'b11;
    tick();
    n_tests++;
    if ({req_ack, dp_opa, dp_opb} !== {2'b01, 8'd5, 8'd7})
      begin n_fail++; $display("FAIL simul_first_ack ack=%b opa=%0d opb=%0d want 01 5 7", req_ack, dp_opa, dp_opb); end
    req_valid = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy_a k=%0d busy=%b want 1", k, busy); end
    end
    tick();
    n_tests++;
    if ({rsp_valid, rsp_data, busy} !== {2'b01, 16'd35, 1'b1})
      begin n_fail++; $display("FAIL simul_rsp0 rspv=%b data=%0d busy=%b want 01 35 1", rsp_valid, rsp_data, busy); end
    tick();
    n_tests++;
    if ({req_ack, dp_opa, dp_opb, busy} !== {2'b10, 8'd255, 8'd255, 1'b1})
      begin n_fail++; $display("FAIL simul_second_ack ack=%b opa=%0d opb=%0d busy=%b want 10 255 255 1",
        req_ack, dp_opa, dp_opb, busy); end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy_b k=%0d busy=%b want 1", k, busy); end
    end
    tick();
    n_tests++;
    if ({rsp_valid, rsp_data} !== {2'b10, 16'd65025})
      begin n_fail++; $display("FAIL simul_rsp1 rspv=%b data=%0d want 10 65025", rsp_valid, rsp_data); end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_idle busy=%b want 0", busy); end
  endtask

  task automatic test_fairness();
    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] exp_p [4] = '{16'd12, 16'd42, 16'd12, 16'd42};
    set_ops(0, 8'd3, 8'd4);
    set_ops(1, 8'd6, 8'd7);
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      tick();
      n_tests++;
      if (req_ack !== exp_g[j])
        begin n_fail++; $display("FAIL fair_grant%0d ack=%b want %b", j, req_ack, exp_g[j]); end
      for (int k = 0; k < 4; k++) tick();
      tick();
      n_tests++;
      if ({rsp_valid, rsp_data} !== {exp_g[j], exp_p[j]})
        begin n_fail++; $display("FAIL fair_rsp%0d rspv=%b data=%0d want %b %0d",
          j, rsp_valid, rsp_data, exp_g[j], exp_p[j]); end
      if (j == 3) req_valid = '0;
    end
    tick();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fair_idle busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    set_ops(0, 8'd9, 8'd9);
    set_ops(1, 8'd2, 8'd2);
    req_valid = 2'b01;
    tick();
    n_tests++;
    if (req_ack !== 2'b01) begin n_fail++; $display("FAIL mid_ack ack=%b want 01", req_ack); end
    req_valid = '0;
    tick();
    tick();
    tick();
    n_tests++;
    if ({dp_sela, dp_selb, dp_sel_shifter} !== exp_ctl[2])
      begin n_fail++; $display("FAIL mid_k2 ctl=%b%b%b want %b", dp_sela, dp_selb, dp_sel_shifter, exp_ctl[2]); end
    rst = 1'b0;
    tick();
    n_tests++;
    if ({req_ack, rsp_valid, rsp_data, busy, dp_load, dp_opa, dp_opb, dp_sela, dp_selb, dp_sel_shifter} !== '0)
      begin n_fail++; $display("FAIL mid_reset_outputs ack=%b rspv=%b busy=%b sel=%b%b%b want all 0",
        req_ack, rsp_valid, busy, dp_sela, dp_selb, dp_sel_shifter); end
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if ({rsp_valid, busy} !== 3'b000)
        begin n_fail++; $display("FAIL mid_no_rsp c=%0d rspv=%b busy=%b want 00 0", c, rsp_valid, busy); end
    end
    req_valid = 2'b11;
    tick();
    n_tests++;
    if (req_ack !== 2'b01) begin n_fail++; $display("FAIL mid_regrant ack=%b want 01", req_ack); end
    req_valid = '0;
    for (int k = 0; k < 4; k++) tick();
    tick();
    n_tests++;
    if ({rsp_valid, rsp_data} !== {2'b01, 16'd81})
      begin n_fail++; $display("FAIL mid_rsp rspv=%b data=%0d want 01 81", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_edge();
    // Operands changed after ack must not affect the product.
    set_ops(1, 8'd20, 8'd30);
    req_valid = 2'b10;
    tick();
    n_tests++;
    if ({req_ack, dp_opa, dp_opb} !== {2'b10, 8'd20, 8'd30})
      begin n_fail++; $display("FAIL edge_ack ack=%b opa=%0d opb=%0d want 10 20 30", req_ack, dp_opa, dp_opb); end
    req_valid = '0;
    tick();
    set_ops(1, 8'd1, 8'd1);
    n_tests++;
    if ({dp_opa, dp_opb, dp_load} !== '0)
      begin n_fail++; $display("FAIL edge_ops_gated opa=%0d opb=%0d load=%b want 0", dp_opa, dp_opb, dp_load); end
    for (int k = 1; k < 4; k++) tick();
    tick();
    n_tests++;
    if ({rsp_valid, rsp_data} !== {2'b10, 16'd600})
      begin n_fail++; $display("FAIL edge_late_ops rspv=%b data=%0d want 10 600", rsp_valid, rsp_data); end
    tick();
    // Zero operand, with requester 1 raising and dropping its request mid-job.
    set_ops(0, 8'd0, 8'd200);
    req_valid = 2'b01;
    tick();
    n_tests++;
    if (req_ack !== 2'b01) begin n_fail++; $display("FAIL edge_zero_ack ack=%b want 01", req_ack); end
    req_valid = '0;
    tick();
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    n_tests++;
    if ({rsp_valid, rsp_data} !== {2'b01, 16'd0})
      begin n_fail++; $display("FAIL edge_zero_rsp rspv=%b data=%0d want 01 0", rsp_valid, rsp_data); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if ({req_ack, rsp_valid, busy} !== 5'b0)
        begin n_fail++; $display("FAIL edge_dropped c=%0d ack=%b rspv=%b busy=%b want 00 00 0",
          c, req_ack, rsp_valid, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_reset_mid();
    test_edge();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
